// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe engine: FSM states, player
// encodings, the eight winning lines and the cursor-to-tile mapping.
package ttt_pkg;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    CHECK = 2'd1,
    WIN   = 2'd2,
    DRAW  = 2'd3
  } state_t;

  localparam logic PLAYER_X = 1'b0;
  localparam logic PLAYER_O = 1'b1;

  // Index 0..2 rows, 3..5 columns, 6..7 diagonals; bit k is tile k (row-major).
  localparam logic [7:0][8:0] WIN_LINES = {
    9'h054, 9'h111,
    9'h124, 9'h092, 9'h049,
    9'h1C0, 9'h038, 9'h007
  };

  function automatic logic [3:0] cursor_idx(input logic [1:0] row, input logic [1:0] col);
    return ({2'b00, row} * 4'd3) + {2'b00, col};
  endfunction

endpackage

// File: rtl/win_checker.sv
// Combinational line detector: reports every completed same-shape line as a
// tile mask, plus whether the board is full.
module win_checker
  import ttt_pkg::*;
(
  input  logic [8:0] occ,
  input  logic [8:0] shape,
  output logic [8:0] win_mask,
  output logic       full
);

  logic [7:0][8:0] line_mask;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_line
      logic all_occ;
      logic all_x;
      logic all_o;
      assign all_occ = ((occ & WIN_LINES[gi]) == WIN_LINES[gi]);
      assign all_x   = ((shape & WIN_LINES[gi]) == 9'h000);
      assign all_o   = ((shape & WIN_LINES[gi]) == WIN_LINES[gi]);
      assign line_mask[gi] = (all_occ && (all_x || all_o)) ? WIN_LINES[gi] : 9'h000;
    end
  endgenerate

  always_comb begin
    win_mask = 9'h000;
    for (int i = 0; i < 8; i++) begin
      win_mask = win_mask | line_mask[i];
    end
  end

  assign full = &occ;

endmodule

// File: rtl/game_controller.sv
// Tic-tac-toe engine: button edge detection, cursor, board, turn/win/draw FSM
// and the blinking ghost piece composed onto the renderer's tiles/color inputs.
module game_controller
  import ttt_pkg::*;
#(
  parameter int BLINK_DIV = 12_500_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_sel,
  input  logic        btn_new,
  output logic [17:0] tiles,
  output logic [8:0]  color,
  output logic [1:0]  state,
  output logic        turn,
  output logic [1:0]  winner
);

  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

  state_t        state_q, state_d;
  logic [8:0]    occ_q, occ_d, shape_q, shape_d, win_mask_q, win_mask_d;
  logic [1:0]    row_q, row_d, col_q, col_d, winner_q, winner_d;
  logic          turn_q, turn_d, phase_q, phase_d, armed_q, armed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    prev_q, prev_d;

  logic [5:0] btn_vec, ev;
  logic [3:0] cur_idx;
  logic       cur_occ;
  logic [8:0] line_mask;
  logic       board_full;

  win_checker u_win_checker (
    .occ      (occ_q),
    .shape    (shape_q),
    .win_mask (line_mask),
    .full     (board_full)
  );

  // Bit order doubles as action priority: new, sel, up, down, left, right.
  assign btn_vec = {btn_new, btn_sel, btn_up, btn_down, btn_left, btn_right};
  // armed_q is low only on the first edge after reset, so held buttons just load history.
  assign ev      = btn_vec & ~prev_q & {6{armed_q}};
  assign cur_idx = cursor_idx(row_q, col_q);
  assign cur_occ = occ_q[cur_idx];

  always_comb begin
    state_d    = state_q;
    occ_d      = occ_q;
    shape_d    = shape_q;
    win_mask_d = win_mask_q;
    row_d      = row_q;
    col_d      = col_q;
    winner_d   = winner_q;
    turn_d     = turn_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    armed_d    = 1'b1;
    prev_d     = btn_vec;

    if (state_q == PLAY) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    if (ev[5]) begin
      state_d    = PLAY;
      occ_d      = 9'h000;
      shape_d    = 9'h000;
      win_mask_d = 9'h000;
      row_d      = 2'd1;
      col_d      = 2'd1;
      winner_d   = 2'b00;
      turn_d     = PLAYER_X;
      phase_d    = 1'b0;
      cnt_d      = '0;
    end else begin
      case (state_q)
        PLAY: begin
          if (ev[4]) begin
            if (!cur_occ) begin
              occ_d[cur_idx]   = 1'b1;
              shape_d[cur_idx] = turn_q;
              state_d          = CHECK;
            end
          end else if (ev[3]) begin
            row_d = (row_q == 2'd0) ? 2'd2 : row_q - 2'd1;
          end else if (ev[2]) begin
            row_d = (row_q == 2'd2) ? 2'd0 : row_q + 2'd1;
          end else if (ev[1]) begin
            col_d = (col_q == 2'd0) ? 2'd2 : col_q - 2'd1;
          end else if (ev[0]) begin
            col_d = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
          end
        end
        CHECK: begin
          if (line_mask != 9'h000) begin
            state_d    = WIN;
            winner_d   = {turn_q, ~turn_q};
            win_mask_d = line_mask;
          end else if (board_full) begin
            state_d  = DRAW;
            winner_d = 2'b11;
          end else begin
            turn_d  = ~turn_q;
            state_d = PLAY;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= PLAY;
      occ_q      <= 9'h000;
      shape_q    <= 9'h000;
      win_mask_q <= 9'h000;
      row_q      <= 2'd1;
      col_q      <= 2'd1;
      winner_q   <= 2'b00;
      turn_q     <= PLAYER_X;
      phase_q    <= 1'b0;
      cnt_q      <= '0;
      armed_q    <= 1'b0;
      prev_q     <= 6'b000000;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      shape_q    <= shape_d;
      win_mask_q <= win_mask_d;
      row_q      <= row_d;
      col_q      <= col_d;
      winner_q   <= winner_d;
      turn_q     <= turn_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      armed_q    <= armed_d;
      prev_q     <= prev_d;
    end
  end

  always_comb begin
    tiles = 18'h00000;
    color = 9'h000;
    for (int k = 0; k < 9; k++) begin
      tiles[2*k]   = occ_q[k];
      tiles[2*k+1] = shape_q[k];
      if (state_q == PLAY && cur_idx == k[3:0]) begin
        if (!occ_q[k]) begin
          if (phase_q) begin
            tiles[2*k]   = 1'b1;
            tiles[2*k+1] = turn_q;
            color[k]     = 1'b1;
          end
        end else begin
          color[k] = phase_q;
        end
      end
    end
    if (state_q == WIN) color = win_mask_q;
    if (state_q == DRAW) color = 9'h1FF;
  end

  assign state  = state_q;
  assign turn   = turn_q;
  assign winner = winner_q;

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller with BLINK_DIV=4: vector table for a full
// X-wins game plus hand sequences for blink, wrap, draw, priority and reset.
module tb_game_controller;

  localparam logic [5:0] BN = 6'b100000;
  localparam logic [5:0] BS = 6'b010000;
  localparam logic [5:0] BU = 6'b001000;
  localparam logic [5:0] BD = 6'b000100;
  localparam logic [5:0] BL = 6'b000010;
  localparam logic [5:0] BR = 6'b000001;
  localparam logic [5:0] BZ = 6'b000000;

  logic        clk;
  logic        reset;
  logic [5:0]  btns;
  logic [17:0] tiles;
  logic [8:0]  color;
  logic [1:0]  st;
  logic        turn;
  logic [1:0]  winner;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int cur_m     = 4;

  typedef struct {
    logic [5:0]  btn;
    logic [17:0] tiles;
    logic [17:0] dc;
    logic [1:0]  st;
    logic        turn;
    logic [1:0]  winner;
    logic        cc;
    logic [8:0]  color;
  } vec_t;

  vec_t vec [40];
  int   nvec = 0;

  game_controller #(.BLINK_DIV(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_up    (btns[3]),
    .btn_down  (btns[2]),
    .btn_left  (btns[1]),
    .btn_right (btns[0]),
    .btn_sel   (btns[4]),
    .btn_new   (btns[5]),
    .tiles     (tiles),
    .color     (color),
    .state     (st),
    .turn      (turn),
    .winner    (winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h required %0h", name, act, exp);
    else pass_cnt++;
    $display("check %-14s got %0h required %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [5:0] b);
    btns = b;
    tick();
    btns = BZ;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cur_m = 4;
  endtask

  // Waits (bounded) for the ghost to appear and checks it sits on tile exp.
  task automatic check_cursor(input int exp);
    int n = 0;
    while (color == 9'h000 && n < 12) begin
      tick();
      n++;
    end
    chk("cursor", {23'd0, color}, 32'd1 << exp);
  endtask

  task automatic place(input int idx);
    while ((cur_m % 3) != (idx % 3)) begin
      press(BR);
      cur_m = (cur_m / 3) * 3 + ((cur_m % 3) + 1) % 3;
    end
    while ((cur_m / 3) != (idx / 3)) begin
      press(BD);
      cur_m = (((cur_m / 3) + 1) % 3) * 3 + (cur_m % 3);
    end
    press(BS);
  endtask

  function automatic vec_t mk(input logic [5:0] b, input logic [17:0] t, input logic [17:0] d,
                              input logic [1:0] s, input logic tu, input logic [1:0] w,
                              input logic c, input logic [8:0] col);
    vec_t v;
    v.btn = b; v.tiles = t; v.dc = d; v.st = s; v.turn = tu; v.winner = w; v.cc = c; v.color = col;
    return v;
  endfunction

  task automatic add(input vec_t v);
    vec[nvec] = v;
    nvec++;
  endtask

  initial begin
    // X takes the top row with O on 3 and 4; dc masks an empty cursor tile's ghost.
    add(mk(BU, 18'h00000, 18'h0000C, 2'd0, 1'b0, 2'b00, 1'b0, 9'h000));
    add(mk(BZ, 18'h00000, 18'h0000C, 2'd0, 1'b0, 2'b00, 1'b0, 9'h000));
    add(mk(BL, 18'h00000, 18'h00003, 2'd0, 1'b0, 2'b00, 1'b0, 9'h000));
    add(mk(BZ, 18'h00000, 18'h00003, 2'd0, 1'b0, 2'b00, 1'b0, 9'h000));
    add(mk(BS, 18'h00001, 18'h00000, 2'd1, 1'b0, 2'b00, 1'b0, 9'h000));
    add(mk(BZ, 18'h00001, 18'h00000, 2'd0, 1'b1, 2'b00, 1'b0, 9'h000));
    add(mk(BD, 18'h00001, 18'h000C0, 2'd0, 1'b1, 2'b00, 1'b0, 9'h000));
    add(mk(BZ, 18'h00001, 18'h000C0, 2'd0, 1'b1, 2'b00, 1'b0, 9'h000));
    add(mk(BS, 18'h000C1, 18'h00000, 2'd1, 1'b1, 2'b00, 1'b0, 9'h000));
    add(mk(BZ, 18'h000C1, 18'h00000, 2'd0, 1'b0, 2'b00, 1'b0, 9'h000));
    add(mk(BU, 18'h000C1, 18'h00000, 2'd0, 1'b0, 2'b00, 1'b0, 9'h000));
    add(mk(BZ, 18'h000C1, 18'h00000, 2'd0, 1'b0, 2'b00, 1'b0, 9'h000));
    add(mk(BR, 18'h000C1, 18'h0000C, 2'd0, 1'b0, 2'b00, 1'b0, 9'h000));
    add(mk(BZ, 18'h000C1, 18'h0000C, 2'd0, 1'b0, 2'b00, 1'b0, 9'h000));
    add(mk(BS, 18'h000C5, 18'h00000, 2'd1, 1'b0, 2'b00, 1'b0, 9'h000));
    add(mk(BZ, 18'h000C5, 18'h00000, 2'd0, 1'b1, 2'b00, 1'b0, 9'h000));
    add(mk(BD, 18'h000C5, 18'h00300, 2'd0, 1'b1, 2'b00, 1'b0, 9'h000));
    add(mk(BZ, 18'h000C5, 18'h00300, 2'd0, 1'b1, 2'b00, 1'b0, 9'h000));
    add(mk(BS, 18'h003C5, 18'h00000, 2'd1, 1'b1, 2'b00, 1'b0, 9'h000));
    add(mk(BZ, 18'h003C5, 18'h00000, 2'd0, 1'b0, 2'b00, 1'b0, 9'h000));
    add(mk(BU, 18'h003C5, 18'h00000, 2'd0, 1'b0, 2'b00, 1'b0, 9'h000));
    add(mk(BZ, 18'h003C5, 18'h00000, 2'd0, 1'b0, 2'b00, 1'b0, 9'h000));
    add(mk(BR, 18'h003C5, 18'h00030, 2'd0, 1'b0, 2'b00, 1'b0, 9'h000));
    add(mk(BZ, 18'h003C5, 18'h00030, 2'd0, 1'b0, 2'b00, 1'b0, 9'h000));
    add(mk(BS, 18'h003D5, 18'h00000, 2'd1, 1'b0, 2'b00, 1'b0, 9'h000));
    add(mk(BZ, 18'h003D5, 18'h00000, 2'd2, 1'b0, 2'b01, 1'b1, 9'h007));
    add(mk(BS, 18'h003D5, 18'h00000, 2'd2, 1'b0, 2'b01, 1'b1, 9'h007));
    add(mk(BZ, 18'h003D5, 18'h00000, 2'd2, 1'b0, 2'b01, 1'b1, 9'h007));
    add(mk(BL, 18'h003D5, 18'h00000, 2'd2, 1'b0, 2'b01, 1'b1, 9'h007));
    add(mk(BZ, 18'h003D5, 18'h00000, 2'd2, 1'b0, 2'b01, 1'b1, 9'h007));

    btns  = BZ;
    reset = 1'b1;

    // Reset state and blink timing.
    do_reset();
    chk("rst_tiles", {14'd0, tiles}, 32'h0);
    chk("rst_color", {23'd0, color}, 32'h0);
    chk("rst_state", {30'd0, st}, 32'd0);
    chk("rst_turn", {31'd0, turn}, 32'd0);
    chk("rst_winner", {30'd0, winner}, 32'd0);
    repeat (3) tick();
    chk("blink3_tile", {30'd0, tiles[9:8]}, 32'd0);
    tick();
    chk("blink4_tile", {30'd0, tiles[9:8]}, 32'd1);
    chk("blink4_color", {31'd0, color[4]}, 32'd1);
    repeat (4) tick();
    chk("blink8_tile", {30'd0, tiles[9:8]}, 32'd0);
    chk("blink8_color", {31'd0, color[4]}, 32'd0);

    // A button held through reset deassertion must not act.
    btns = BS;
    do_reset();
    tick();
    tick();
    chk("held_tiles", {14'd0, tiles}, 32'h0);
    chk("held_state", {30'd0, st}, 32'd0);
    btns = BZ;

    // Place X at centre, then a rejected sel on the occupied tile.
    do_reset();
    tick();
    btns = BS;
    tick();
    chk("sel_tile4", {30'd0, tiles[9:8]}, 32'd1);
    chk("sel_check", {30'd0, st}, 32'd1);
    btns = BZ;
    tick();
    chk("sel_turn", {31'd0, turn}, 32'd1);
    chk("sel_play", {30'd0, st}, 32'd0);
    btns = BS;
    tick();
    chk("occ_state", {30'd0, st}, 32'd0);
    btns = BZ;
    tick();
    chk("occ_tiles", {14'd0, tiles}, 32'h100);
    chk("occ_turn", {31'd0, turn}, 32'd1);

    // Cursor wrap in all four directions.
    do_reset();
    tick();
    press(BL); check_cursor(3);
    press(BL); check_cursor(5);
    press(BU); check_cursor(2);
    press(BU); check_cursor(8);
    press(BR); check_cursor(6);
    press(BD); check_cursor(0);

    // Table-driven winning game.
    do_reset();
    tick();
    for (int i = 0; i < nvec; i++) begin
      btns = vec[i].btn;
      tick();
      chk($sformatf("v%0d_tiles", i), {14'd0, tiles & ~vec[i].dc}, {14'd0, vec[i].tiles & ~vec[i].dc});
      chk($sformatf("v%0d_state", i), {30'd0, st}, {30'd0, vec[i].st});
      chk($sformatf("v%0d_turn", i), {31'd0, turn}, {31'd0, vec[i].turn});
      chk($sformatf("v%0d_winner", i), {30'd0, winner}, {30'd0, vec[i].winner});
      if (vec[i].cc) chk($sformatf("v%0d_color", i), {23'd0, color}, {23'd0, vec[i].color});
    end
    btns = BZ;

    // New game out of WIN, then a drawn game.
    press(BN);
    cur_m = 4;
    chk("new_tiles", {14'd0, tiles}, 32'h0);
    chk("new_state", {30'd0, st}, 32'd0);
    chk("new_winner", {30'd0, winner}, 32'd0);
    place(0); place(1); place(2); place(4); place(3);
    place(5); place(7); place(6); place(8);
    chk("draw_state", {30'd0, st}, 32'd3);
    chk("draw_winner", {30'd0, winner}, 32'd3);
    chk("draw_color", {23'd0, color}, 32'h1FF);
    chk("draw_tiles", {14'd0, tiles}, 32'h17F5D);
    chk("draw_turn", {31'd0, turn}, 32'd0);
    press(BN);
    chk("new2_tiles", {14'd0, tiles}, 32'h0);
    chk("new2_state", {30'd0, st}, 32'd0);
    chk("new2_turn", {31'd0, turn}, 32'd0);
    chk("new2_winner", {30'd0, winner}, 32'd0);
    check_cursor(4);

    // sel beats right in the same cycle; cursor must stay on tile 4.
    do_reset();
    tick();
    btns = BS | BR;
    tick();
    chk("pri_tiles", {14'd0, tiles}, 32'h100);
    chk("pri_state", {30'd0, st}, 32'd1);
    btns = BZ;
    tick();
    press(BS);
    chk("pri_cur_tiles", {14'd0, tiles}, 32'h100);
    chk("pri_cur_turn", {31'd0, turn}, 32'd1);

    // Asynchronous reset while in CHECK.
    press(BL);
    btns = BS;
    tick();
    chk("pre_rst_state", {30'd0, st}, 32'd1);
    chk("pre_rst_tiles", {14'd0, tiles}, 32'h1C0);
    btns  = BZ;
    reset = 1'b1;
    #1;
    chk("arst_tiles", {14'd0, tiles}, 32'h0);
    chk("arst_color", {23'd0, color}, 32'h0);
    chk("arst_state", {30'd0, st}, 32'd0);
    chk("arst_turn", {31'd0, turn}, 32'd0);
    chk("arst_winner", {30'd0, winner}, 32'd0);

    // new outranks sel.
    do_reset();
    tick();
    btns = BN | BS;
    tick();
    btns = BZ;
    chk("new_pri_tiles", {14'd0, tiles}, 32'h0);
    chk("new_pri_state", {30'd0, st}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
